// File: rtl/div_pkg.sv
// div_pkg: shared types, default width and magnitude helper for the sequential divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_t;
  localparam int DIV_W = 6;
  function automatic logic [31:0] abs_mag(input logic signed [31:0] value);
    return value[31] ? 32'(-value) : value;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration on unsigned magnitudes
module div_step
  import div_pkg::*;
#(
  parameter int width = DIV_W
) (
  input  logic [width:0]   prem,
  input  logic             dbit,
  input  logic [width-1:0] dvs,
  output logic [width:0]   nrem,
  output logic             qbit
);
  logic [width+1:0] diff;
  // the extra top bit of diff acts as the borrow of the trial subtraction
  assign diff = {prem, dbit} - {2'b00, dvs};
  assign qbit = ~diff[width+1];
  assign nrem = qbit ? diff[width:0] : {prem[width-1:0], dbit};
endmodule

// File: rtl/seq_div.sv
// seq_div: signed restoring divider, one quotient bit per clock with start/busy/done handshake
module seq_div
  import div_pkg::*;
#(
  parameter int width = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] in1,
  input  logic [width-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] quot,
  output logic [width-1:0] rem,
  output logic             dz,
  output logic             ovf
);
  localparam int cw = $clog2(width) + 1;
  div_state_t state, nxt;
  logic [cw-1:0] cnt;
  logic [width:0] prem, nrem;
  logic [width-1:0] acc, dvs;
  logic sq, sr, dz_p, ovf_p, qbit;
  div_step #(.width(width)) u_step (
    .prem(prem),
    .dbit(acc[width-1]),
    .dvs (dvs),
    .nrem(nrem),
    .qbit(qbit)
  );
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) nxt = start ? CALC : IDLE;
    else if (state == CALC) nxt = (cnt == cw'(width - 1)) ? FIX : CALC;
  end
  assign busy = state != IDLE;
  // acc starts as the dividend magnitude and fills with quotient bits as it shifts out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      prem  <= '0;
      acc   <= '0;
      dvs   <= '0;
      sq    <= 1'b0;
      sr    <= 1'b0;
      dz_p  <= 1'b0;
      ovf_p <= 1'b0;
    end else begin
      state <= nxt;
      done  <= state == FIX;
      if (state == IDLE && start) begin
        sq    <= in1[width-1];
        sr    <= in1[width-1] ^ in2[width-1];
        acc   <= width'(abs_mag(32'(signed'(in1))));
        dvs   <= width'(abs_mag(32'(signed'(in2))));
        prem  <= '0;
        cnt   <= '0;
        dz_p  <= in2 == '0;
        ovf_p <= in1 == {1'b1, {(width-1){1'b0}}} && in2 == '1;
      end
      if (state == CALC) begin
        prem <= nrem;
        acc  <= {acc[width-2:0], qbit};
        cnt  <= cnt + cw'(1);
      end
      if (state == FIX) begin
        quot <= dz_p ? '1 : sr ? -acc : acc;
        rem  <= sq ? -prem[width-1:0] : prem[width-1:0];
        dz   <= dz_p;
        ovf  <= ovf_p;
      end
    end
  end
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: scoreboard bench for seq_div at width 6
module tb_seq_div;
  localparam int W = 6;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic busy, done, dz, ovf;
  logic [W-1:0] quot, rem;
  typedef struct {
    logic [W-1:0] q, r;
    logic dz, ovf;
    int acc;
  } exp_t;
  exp_t sb[$];
  exp_t e_m;
  int nvec = 0, nerr = 0, cyc = 0, ndone = 0, bcnt = 0;
  logic [W-1:0] last_q = '0;
  seq_div #(.width(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .dz(dz), .ovf(ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.dz = 1'b0;
    e.ovf = 1'b0;
    e.acc = 0;
    if (b == 0) begin
      e.q = '1;
      e.r = W'(a);
      e.dz = 1'b1;
    end else if (a == -(1 << (W - 1)) && b == -1) begin
      e.q = W'(a);
      e.r = '0;
      e.ovf = 1'b1;
    end else begin
      e.q = W'(a / b);
      e.r = W'(a % b);
    end
    return e;
  endfunction
  always @(negedge clk) if (!rst) begin
    if (busy) begin
      bcnt++;
      check("hold_q", $signed(quot), $signed(last_q));
    end
    if (done) begin
      check("done_busy", busy, 0);
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        e_m = sb.pop_front();
        check("quot", $signed(quot), $signed(e_m.q));
        check("rem", $signed(rem), $signed(e_m.r));
        check("dz", dz, e_m.dz);
        check("ovf", ovf, e_m.ovf);
        check("latency", cyc - e_m.acc, W + 1);
        check("busy_len", bcnt, W + 1);
        last_q = e_m.q;
      end
      bcnt = 0;
      ndone++;
    end
  end
  task automatic issue(input int a, input int b);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    in1 = W'(a);
    in2 = W'(b);
    e = model(a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    in1 = W'($urandom);
    in2 = W'($urandom);
  endtask
  task automatic wait_done();
    int n0 = ndone;
    for (int i = 0; i < 20 && ndone == n0; i++) begin
      @(negedge clk);
      #1;
    end
    if (ndone == n0) check("timeout", 0, 1);
  endtask
  task automatic div(input int a, input int b);
    issue(a, b);
    wait_done();
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_quot"}, $signed(quot), 0);
    check({tag, "_rem"}, $signed(rem), 0);
    check({tag, "_dz"}, dz, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask
  initial begin
    exp_t e;
    bit seen;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    div(13, 4);
    div(13, -4);
    div(-13, 4);
    div(-13, -4);
    div(-32, -1);
    div(-32, 1);
    div(7, 0);
    div(6, 3);
    issue(20, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b1;
      in1 = W'($urandom);
      in2 = W'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    in1 = W'(9);
    in2 = W'(2);
    e = model(9, 2);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 in1 = W'(-17);
    in2 = W'(5);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) check("timeout_b2b", 0, 1);
    e = model(-17, 5);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    issue(11, 2);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("rst_mid");
    sb.delete();
    bcnt = 0;
    last_q = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    div(5, 2);
    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
